// File: rtl/wm_controller.sv
// wm_controller -- washing-machine sequencer.
//
// Walks a wash cycle FILL -> WASH -> RINSE (one or two passes) -> SPIN -> DONE.
// Each phase is timed by an external phase timer that this block enables and
// clears. A phase completes on the cycle the timer reaches that phase's limit,
// so a phase lasts limit+1 cycles.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               pulse: begin a cycle from IDLE, resume from PAUSE
//   pause_req           pulse: pause a running phase
//   cancel              pulse: abort to IDLE from any state
//   door_closed         level: 1 = door shut; opening mid-cycle faults
//   extra_rinse         level: sampled on the accepted start, adds a rinse pass
//   tmr_count[3:0]      current phase timer count
//   tmr_en, tmr_clr     phase timer enable / clear
//   water_valve, motor_wash, motor_spin, drain_valve, door_lock
//                       actuator drives
//   done, fault         cycle complete / door-open fault
//   state[2:0]          current state code (also serves as the debug view)
//
// Event priority within one cycle:
//   reset > cancel > door fault > phase completion > pause_req > start.
// All outputs are decodes of the state register; tmr_clr additionally pulses
// in the completing cycle so the next phase starts from count 0.

module wm_controller #(
    parameter int FILL_T  = 3,
    parameter int WASH_T  = 5,
    parameter int RINSE_T = 4,
    parameter int SPIN_T  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause_req,
    input  logic       cancel,
    input  logic       door_closed,
    input  logic       extra_rinse,
    input  logic [3:0] tmr_count,
    output logic       tmr_en,
    output logic       tmr_clr,
    output logic       water_valve,
    output logic       motor_wash,
    output logic       motor_spin,
    output logic       drain_valve,
    output logic       door_lock,
    output logic       done,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_DONE  = 3'd5,
        S_PAUSE = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    state_t     state_q, state_d;
    state_t     resume_q, resume_d;   // phase to return to from PAUSE
    logic [1:0] passes_q, passes_d;   // rinse passes still to run (1 or 2)

    logic       timed;
    logic [3:0] limit;
    logic       phase_done;

    always_comb begin
        timed = (state_q == S_FILL) || (state_q == S_WASH) ||
                (state_q == S_RINSE) || (state_q == S_SPIN);
        case (state_q)
            S_FILL:  limit = 4'(FILL_T);
            S_WASH:  limit = 4'(WASH_T);
            S_RINSE: limit = 4'(RINSE_T);
            S_SPIN:  limit = 4'(SPIN_T);
            default: limit = 4'd0;
        endcase
        phase_done = timed && (tmr_count == limit);
    end

    // Next-state logic, written as an if/else chain in priority order.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        passes_d = passes_q;
        if (cancel && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && door_closed) begin
                        state_d  = S_FILL;
                        passes_d = extra_rinse ? 2'd2 : 2'd1;
                    end
                end
                S_FILL, S_WASH, S_RINSE, S_SPIN: begin
                    if (!door_closed) begin
                        state_d = S_FAULT;
                    end else if (phase_done) begin
                        // A pause_req arriving now is dropped on purpose.
                        case (state_q)
                            S_FILL:  state_d = S_WASH;
                            S_WASH:  state_d = S_RINSE;
                            S_RINSE: begin
                                if (passes_q == 2'd2) begin
                                    state_d  = S_RINSE;
                                    passes_d = 2'd1;
                                end else begin
                                    state_d = S_SPIN;
                                end
                            end
                            default: state_d = S_DONE;
                        endcase
                    end else if (pause_req) begin
                        state_d  = S_PAUSE;
                        resume_d = state_q;
                    end
                end
                S_PAUSE: begin
                    // Timer is disabled here, so the resumed phase restarts at 0.
                    if (!door_closed) begin
                        state_d = S_FAULT;
                    end else if (start) begin
                        state_d = resume_q;
                    end
                end
                S_DONE: begin
                    if (!door_closed) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    // FAULT: only cancel or reset leave.
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            resume_q <= S_IDLE;
            passes_q <= 2'd1;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            passes_q <= passes_d;
        end
    end

    always_comb begin
        tmr_en      = timed;
        tmr_clr     = !timed || phase_done;
        water_valve = (state_q == S_FILL) || (state_q == S_RINSE);
        motor_wash  = (state_q == S_WASH) || (state_q == S_RINSE);
        motor_spin  = (state_q == S_SPIN);
        drain_valve = (state_q == S_SPIN);
        door_lock   = timed || (state_q == S_PAUSE);
        done        = (state_q == S_DONE);
        fault       = (state_q == S_FAULT);
        state       = state_q;
    end

endmodule

// File: tb/tb_wm_controller.sv
// Testbench for wm_controller: external phase timer, reference model with a
// scoreboard, directed vector table, hand-written corner sequences and a
// randomized run.

module tb_wm_controller;

    localparam int FILL_T  = 3;
    localparam int WASH_T  = 5;
    localparam int RINSE_T = 4;
    localparam int SPIN_T  = 6;

    localparam int IDLE = 0, FILL = 1, WASH = 2, RINSE = 3,
                   SPIN = 4, DONE = 5, PAUSE = 6, FAULT = 7;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, pause_req = 1'b0, cancel = 1'b0;
    logic       door_closed = 1'b1, extra_rinse = 1'b0;
    logic [3:0] tmr_cnt = 4'd0;
    logic       tmr_en, tmr_clr, water_valve, motor_wash, motor_spin;
    logic       drain_valve, door_lock, done, fault;
    logic [2:0] state;
    logic [8:0] outs_vec;

    always #5 clk = ~clk;

    wm_controller #(
        .FILL_T(FILL_T), .WASH_T(WASH_T), .RINSE_T(RINSE_T), .SPIN_T(SPIN_T)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause_req(pause_req),
        .cancel(cancel), .door_closed(door_closed), .extra_rinse(extra_rinse),
        .tmr_count(tmr_cnt), .tmr_en(tmr_en), .tmr_clr(tmr_clr),
        .water_valve(water_valve), .motor_wash(motor_wash),
        .motor_spin(motor_spin), .drain_valve(drain_valve),
        .door_lock(door_lock), .done(done), .fault(fault), .state(state)
    );

    assign outs_vec = {tmr_en, tmr_clr, water_valve, motor_wash, motor_spin,
                       drain_valve, door_lock, done, fault};

    // External phase timer as described for the system.
    always @(posedge clk) begin
        if (!tmr_en || tmr_clr) tmr_cnt <= 4'd0;
        else                    tmr_cnt <= tmr_cnt + 4'd1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Tracks cycles spent in the current phase rather than the timer value.
    int m_st = IDLE, m_res = IDLE, m_pass = 1, m_el = 0;
    logic [8:0] out_tab [8];   // {en,clr,water,wash,spin,drain,lock,done,fault}

    function automatic bit is_timed(input int s);
        return (s >= FILL) && (s <= SPIN);
    endfunction

    function automatic int lim(input int s);
        case (s)
            FILL:    return FILL_T;
            WASH:    return WASH_T;
            RINSE:   return RINSE_T;
            SPIN:    return SPIN_T;
            default: return -1;
        endcase
    endfunction

    function automatic logic [8:0] exp_outs();
        logic [8:0] v;
        v = out_tab[m_st];
        if (is_timed(m_st) && m_el == lim(m_st)) v[7] = 1'b1;
        return v;
    endfunction

    task automatic model_step(input logic s, p, c, d, x, r);
        int  nxt;
        bit  comp;
        nxt  = m_st;
        comp = is_timed(m_st) && (m_el == lim(m_st));
        if (r) begin
            nxt = IDLE; m_pass = 1; m_res = IDLE;
        end else if (c && m_st != IDLE) begin
            nxt = IDLE;
        end else if (m_st == IDLE) begin
            if (s && d) begin nxt = FILL; m_pass = x ? 2 : 1; end
        end else if (is_timed(m_st) || m_st == PAUSE) begin
            if (!d) nxt = FAULT;
            else if (m_st == PAUSE) begin
                if (s) nxt = m_res;
            end else if (comp) begin
                if (m_st == RINSE && m_pass == 2) begin nxt = RINSE; m_pass = 1; end
                else if (m_st == RINSE) nxt = SPIN;
                else if (m_st == SPIN)  nxt = DONE;
                else                    nxt = m_st + 1;
            end else if (p) begin
                nxt = PAUSE; m_res = m_st;
            end
        end else if (m_st == DONE) begin
            if (!d) nxt = IDLE;
        end
        m_el = (!r && nxt == m_st && is_timed(m_st) && !comp) ? m_el + 1 : 0;
        m_st = nxt;
    endtask

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic s, p, c, d, x, r);
        logic [11:0] e;
        start = s; pause_req = p; cancel = c;
        door_closed = d; extra_rinse = x; reset = r;
        model_step(s, p, c, d, x, r);
        exp_q.push_back({3'(m_st), exp_outs()});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("model_state", int'(state), int'(e[11:9]));
        check("model_outputs", int'(outs_vec), int'(e[8:0]));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic wait_state(input int s, input int maxc);
        int n;
        n = 0;
        while (int'(state) != s && n < maxc) begin idle(); n++; end
        check("wait_state", int'(state), s);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int   reps;
        logic s, p, c, d, x;
        int   st;
    } vec_t;
    vec_t vt [19];

    initial begin
        int n, rinse, clrs;

        out_tab[IDLE]  = 9'b010000000;
        out_tab[FILL]  = 9'b101000100;
        out_tab[WASH]  = 9'b100100100;
        out_tab[RINSE] = 9'b101100100;
        out_tab[SPIN]  = 9'b100011100;
        out_tab[DONE]  = 9'b010000010;
        out_tab[PAUSE] = 9'b010000100;
        out_tab[FAULT] = 9'b010000001;

        //        reps s  p  c  d  x  expected state
        vt[0]  = '{1, 1, 0, 0, 1, 0, FILL};
        vt[1]  = '{3, 0, 0, 0, 1, 0, FILL};   // counts 1..3
        vt[2]  = '{1, 0, 1, 0, 1, 0, WASH};   // pause dropped on completion
        vt[3]  = '{3, 0, 0, 0, 1, 0, WASH};   // count reaches 3
        vt[4]  = '{1, 0, 1, 0, 1, 0, PAUSE};
        vt[5]  = '{2, 0, 0, 0, 1, 0, PAUSE};
        vt[6]  = '{1, 1, 0, 0, 1, 0, WASH};   // resume at count 0
        vt[7]  = '{5, 0, 0, 0, 1, 0, WASH};   // six WASH cycles total
        vt[8]  = '{1, 0, 0, 0, 1, 0, RINSE};
        vt[9]  = '{2, 0, 0, 0, 1, 0, RINSE};
        vt[10] = '{1, 0, 0, 1, 0, 0, IDLE};   // cancel beats door fault
        vt[11] = '{1, 1, 0, 0, 0, 0, IDLE};   // start with door open ignored
        vt[12] = '{1, 1, 0, 0, 1, 0, FILL};
        vt[13] = '{1, 0, 1, 0, 1, 0, PAUSE};
        vt[14] = '{1, 0, 0, 0, 0, 0, FAULT};  // door open while paused
        vt[15] = '{1, 1, 0, 0, 0, 0, FAULT};
        vt[16] = '{1, 1, 0, 0, 1, 0, FAULT};  // start ignored in FAULT
        vt[17] = '{1, 0, 1, 0, 1, 0, FAULT};
        vt[18] = '{1, 0, 0, 1, 1, 0, IDLE};

        // Reset state.
        do_reset();
        check("reset_state", int'(state), IDLE);
        check("reset_outputs", int'(outs_vec), 9'b010000000);

        // Basic cycle: done on the 23rd cycle after start.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n = 1;
        while (!done && n < 40) begin idle(); n++; end
        check("basic_done_cycle", n, 23);
        idle(); idle();
        check("done_hold", int'(done), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("done_door_open", int'(state), IDLE);

        // Extra rinse: two passes, done on the 28th cycle.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n = 1; rinse = 0; clrs = 0;
        while (!done && n < 60) begin
            if (int'(state) == RINSE) begin
                rinse++;
                if (tmr_clr) clrs++;
            end
            idle();
            n++;
        end
        check("extra_done_cycle", n, 28);
        check("extra_rinse_cycles", rinse, 10);
        check("extra_rinse_clr_pulses", clrs, 2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Vector table.
        for (int i = 0; i < 19; i++) begin
            for (int k = 0; k < vt[i].reps; k++) begin
                cycle(vt[i].s, vt[i].p, vt[i].c, vt[i].d, vt[i].x, 1'b0);
                check($sformatf("vec%0d_state", i), int'(state), vt[i].st);
            end
        end

        // Door opens during SPIN.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_state(SPIN, 40);
        idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("spin_fault_state", int'(state), FAULT);
        check("spin_fault_flag", int'(fault), 1);
        check("spin_fault_motor", int'(motor_spin), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("fault_ignores_start", int'(state), FAULT);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("fault_cancel", int'(state), IDLE);

        // Reset mid-RINSE on the second pass, then a single-pass run.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_state(RINSE, 40);
        for (int k = 0; k < 6; k++) idle();
        check("second_pass_rinse", int'(state), RINSE);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("mid_rinse_reset", int'(state), IDLE);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n = 0; rinse = 0;
        while (int'(state) != SPIN && n < 40) begin
            if (int'(state) == RINSE) rinse++;
            idle();
            n++;
        end
        check("post_reset_single_rinse", rinse, 5);

        // Randomized run against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 24) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 299) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
